time_keeper: RTL

- Consumer of the six digit values produced by the time-entry block.
- Loads those digits as hh:mm:ss, validates them, then advances the time once per second while the run switch is on.
- Presents the current time as six BCD digits to the display-driver path.
- Sits between time entry and the 7-segment multiplexer on the Artix-7 clock design.

---
 rtl/time_keeper_pkg.sv | 36 +++
 rtl/time_keeper_bcd_digit_counter.sv | 32 +++
 rtl/time_keeper.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/time_keeper_pkg.sv
// Shared definitions for the time-keeping path.
//   - BCD limit constants, also reused by the time-entry block for clamping.
//   - state_t: HOLD/RUN encoding of the time_keeper control FSM.
//   - load_valid(): checks a six-digit hh:mm:ss entry against the clock limits.
package time_keeper_pkg;

  localparam logic [3:0] SEC_TENS_MAX      = 4'd5;
  localparam logic [3:0] ONES_MAX          = 4'd9;
  localparam logic [3:0] HRS_MAX_TENS      = 4'd2;
  localparam logic [3:0] HRS_MAX_ONES_AT_2 = 4'd3;

  typedef enum logic {
    HOLD = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Entry digits are 6 bits wide, so any value of 10 or more must be
  // rejected here rather than silently truncated to 4 bits.
  function automatic logic load_valid(
    input logic [5:0] ht,
    input logic [5:0] ho,
    input logic [5:0] mt,
    input logic [5:0] mo,
    input logic [5:0] st,
    input logic [5:0] so
  );
    logic hrs_ok;
    hrs_ok = (ht < {2'b00, HRS_MAX_TENS}) ? (ho <= {2'b00, ONES_MAX}) :
             (ht == {2'b00, HRS_MAX_TENS}) ? (ho <= {2'b00, HRS_MAX_ONES_AT_2}) :
             1'b0;
    return hrs_ok &&
           (mt <= {2'b00, SEC_TENS_MAX}) && (mo <= {2'b00, ONES_MAX}) &&
           (st <= {2'b00, SEC_TENS_MAX}) && (so <= {2'b00, ONES_MAX});
  endfunction

endpackage

// File: rtl/time_keeper_bcd_digit_counter.sv
// Single BCD digit that counts 0..MAX and wraps to 0.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   inc          : advance by one this cycle
//   load, ld_val : overwrite the digit (load has priority over inc)
//   val          : current digit value
//   carry        : combinational, high when inc wraps MAX -> 0
module bcd_digit_counter #(
  parameter logic [3:0] MAX = 4'd9
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       inc,
  input  logic       load,
  input  logic [3:0] ld_val,
  output logic [3:0] val,
  output logic       carry
);

  assign carry = inc && (val == MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      val <= 4'd0;
    end else if (load) begin
      val <= ld_val;
    end else if (inc) begin
      val <= (val == MAX) ? 4'd0 : val + 4'd1;
    end
  end

endmodule

// File: rtl/time_keeper.sv
// Time-of-day keeper: loads hh:mm:ss from the entry block, validates it and
// advances it once per second while the run switch is on.
// Ports:
//   clk, rst_n        : system clock, asynchronous active-low reset
//   run_sw            : asynchronous board switch, 1 = count, 0 = hold
//   load, ld_*        : load strobe and six entered digits (6 bits each)
//   hrs_* min_* sec_* : current time as BCD digits (registered)
//   running           : high while in RUN
//   sec_tick          : one-cycle pulse whenever the time advances
//   load_err          : one-cycle pulse when a load is rejected
//   day_wrap          : one-cycle pulse on 23:59:59 -> 00:00:00
//   state_dbg         : control FSM state, for observation only
//
// load is a single-cycle strobe with no ready: it is accepted or rejected in
// the cycle it is high, and a valid load overrides a tick in the same cycle.
module time_keeper
  import time_keeper_pkg::*;
#(
  parameter int TICK_DIV    = 100000000,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run_sw,
  input  logic       load,
  input  logic [5:0] ld_hrs_tens,
  input  logic [5:0] ld_hrs_ones,
  input  logic [5:0] ld_min_tens,
  input  logic [5:0] ld_min_ones,
  input  logic [5:0] ld_sec_tens,
  input  logic [5:0] ld_sec_ones,
  output logic [3:0] hrs_tens,
  output logic [3:0] hrs_ones,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       running,
  output logic       sec_tick,
  output logic       load_err,
  output logic       day_wrap,
  output state_t     state_dbg
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  // Run switch synchronizer
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   run_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], run_sw};
  end

  assign run_s = sync_q[SYNC_STAGES-1];

  // Control FSM
  state_t state, state_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= HOLD;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      HOLD:    if (run_s)  state_nxt = RUN;
      RUN:     if (!run_s) state_nxt = HOLD;
      default: state_nxt = HOLD;
    endcase
  end

  assign running   = (state == RUN);
  assign state_dbg = state;

  // Load decode and tick generation
  logic          ld_ok;
  logic          tick;
  logic          adv;
  logic [PW-1:0] presc;

  assign ld_ok = load && load_valid(ld_hrs_tens, ld_hrs_ones, ld_min_tens,
                                    ld_min_ones, ld_sec_tens, ld_sec_ones);
  assign tick  = (state == RUN) && (presc == PRESC_LAST);
  // Any load cycle (accepted or rejected) swallows the tick.
  assign adv   = tick && !load;

  // The prescaler freezes in HOLD so a pause keeps the fractional second.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              presc <= '0;
    else if (ld_ok)          presc <= '0;
    else if (load)           presc <= presc;
    else if (tick)           presc <= '0;
    else if (state == RUN)   presc <= presc + 1'b1;
  end

  // Minute/second digits: one ripple of combinational carries per tick
  logic so_c, st_c, mo_c, mt_c;

  bcd_digit_counter #(.MAX(ONES_MAX)) u_sec_ones (
    .clk(clk), .rst_n(rst_n), .inc(adv), .load(ld_ok),
    .ld_val(ld_sec_ones[3:0]), .val(sec_ones), .carry(so_c)
  );

  bcd_digit_counter #(.MAX(SEC_TENS_MAX)) u_sec_tens (
    .clk(clk), .rst_n(rst_n), .inc(so_c), .load(ld_ok),
    .ld_val(ld_sec_tens[3:0]), .val(sec_tens), .carry(st_c)
  );

  bcd_digit_counter #(.MAX(ONES_MAX)) u_min_ones (
    .clk(clk), .rst_n(rst_n), .inc(st_c), .load(ld_ok),
    .ld_val(ld_min_ones[3:0]), .val(min_ones), .carry(mo_c)
  );

  bcd_digit_counter #(.MAX(SEC_TENS_MAX)) u_min_tens (
    .clk(clk), .rst_n(rst_n), .inc(mo_c), .load(ld_ok),
    .ld_val(ld_min_tens[3:0]), .val(min_tens), .carry(mt_c)
  );

  // Hours pair: plain 0..9 ones with the 23 -> 00 exception
  logic at_23;
  assign at_23 = (hrs_tens == HRS_MAX_TENS) && (hrs_ones == HRS_MAX_ONES_AT_2);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hrs_tens <= 4'd0;
      hrs_ones <= 4'd0;
    end else if (ld_ok) begin
      hrs_tens <= ld_hrs_tens[3:0];
      hrs_ones <= ld_hrs_ones[3:0];
    end else if (mt_c) begin
      if (at_23) begin
        hrs_tens <= 4'd0;
        hrs_ones <= 4'd0;
      end else if (hrs_ones == ONES_MAX) begin
        hrs_tens <= hrs_tens + 4'd1;
        hrs_ones <= 4'd0;
      end else begin
        hrs_ones <= hrs_ones + 4'd1;
      end
    end
  end

  // Status pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sec_tick <= 1'b0;
      load_err <= 1'b0;
      day_wrap <= 1'b0;
    end else begin
      sec_tick <= adv;
      load_err <= load && !ld_ok;
      day_wrap <= mt_c && at_23;
    end
  end

endmodule
